reg_bank_16x16: RTL and testbench

Architectural register bank for the PT1 CPU: sixteen 16-bit registers written from two writeback sources and exported as one flat 256-bit bus. That bus drives the 16:1 × 16-bit read multiplexer directly downstream. The bank includes a one-entry holding slot that arbitrates the ALU and load writeback ports. It also includes a busy scoreboard consumed by issue logic.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/decoder_4_16.sv | 13 +
 rtl/wb_hold_slot.sv | 76 +++++++
 rtl/reg_bank_16x16.sv | 82 ++++++++
 tb/tb_reg_bank_16x16.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared PT1 CPU register-file types and sizes.
package cpu_pkg;

   localparam int unsigned REG_W      = 16;
   localparam int unsigned NREGS      = 16;
   localparam int unsigned REG_ADDR_W = 4;

   typedef enum logic [0:0] {
      HOLD_EMPTY = 1'b0,
      HOLD_FULL  = 1'b1
   } hold_state_t;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_W-1:0]      data;
   } wb_entry_t;

endpackage

// File: rtl/decoder_4_16.sv
// 4-bit address to 16-bit one-hot decoder with enable.
module decoder_4_16 (
   input  logic        en,
   input  logic [3:0]  addr,
   output logic [15:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[addr] = 1'b1;
   end

endmodule

// File: rtl/wb_hold_slot.sv
// Arbitrates ALU and load writebacks into one write per cycle; a load that
// collides with an ALU write is parked in a one-entry slot until A goes idle.
module wb_hold_slot
   import cpu_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_valid,
   input  logic [REG_ADDR_W-1:0] a_addr,
   input  logic [REG_W-1:0]      a_data,
   input  logic                  b_valid,
   input  logic [REG_ADDR_W-1:0] b_addr,
   input  logic [REG_W-1:0]      b_data,
   output logic                  b_ready,
   output logic                  wr_valid,
   output logic [REG_ADDR_W-1:0] wr_addr,
   output logic [REG_W-1:0]      wr_data
);

   hold_state_t state_q, state_d;
   wb_entry_t   slot_q, slot_d;

   // b_ready depends only on the state flop, never on the valids.
   assign b_ready = (state_q == HOLD_EMPTY);

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      wr_valid = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      case (state_q)
         HOLD_EMPTY: begin
            if (a_valid) begin
               wr_valid = 1'b1;
               wr_addr  = a_addr;
               wr_data  = a_data;
               if (b_valid) begin
                  slot_d  = '{addr: b_addr, data: b_data};
                  state_d = HOLD_FULL;
               end
            end else if (b_valid) begin
               wr_valid = 1'b1;
               wr_addr  = b_addr;
               wr_data  = b_data;
            end
         end
         HOLD_FULL: begin
            if (a_valid) begin
               wr_valid = 1'b1;
               wr_addr  = a_addr;
               wr_data  = a_data;
               // A is newer than the parked load: drop the slot.
               if (a_addr == slot_q.addr) state_d = HOLD_EMPTY;
            end else begin
               wr_valid = 1'b1;
               wr_addr  = slot_q.addr;
               wr_data  = slot_q.data;
               state_d  = HOLD_EMPTY;
            end
         end
         default: state_d = HOLD_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= HOLD_EMPTY;
         slot_q  <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
      end
   end

endmodule

// File: rtl/reg_bank_16x16.sv
// Sixteen 16-bit architectural registers with busy scoreboard and flat output bus.
// Optional REGBANK_R0_ZERO_EN hardwires register 0 to zero.
module reg_bank_16x16
   import cpu_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    a_valid,
   input  logic [REG_ADDR_W-1:0]   a_addr,
   input  logic [REG_W-1:0]        a_data,
   input  logic                    b_valid,
   output logic                    b_ready,
   input  logic [REG_ADDR_W-1:0]   b_addr,
   input  logic [REG_W-1:0]        b_data,
   input  logic                    rsv_valid,
   input  logic [REG_ADDR_W-1:0]   rsv_addr,
   output logic [NREGS-1:0]        busy,
   output logic [REG_W*NREGS-1:0]  data_bus_out
);

   logic                    wr_valid;
   logic [REG_ADDR_W-1:0]   wr_addr;
   logic [REG_W-1:0]        wr_data;
   logic [NREGS-1:0]        wr_onehot;
   logic [NREGS-1:0]        rsv_onehot;
   logic [REG_W*NREGS-1:0]  bank_q, bank_d;
   logic [NREGS-1:0]        busy_q, busy_d;

   wb_hold_slot u_hold (
      .clk      (clk),
      .rst      (rst),
      .a_valid  (a_valid),
      .a_addr   (a_addr),
      .a_data   (a_data),
      .b_valid  (b_valid),
      .b_addr   (b_addr),
      .b_data   (b_data),
      .b_ready  (b_ready),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data)
   );

   decoder_4_16 u_wr_dec (
      .en     (wr_valid),
      .addr   (wr_addr),
      .onehot (wr_onehot)
   );

   decoder_4_16 u_rsv_dec (
      .en     (rsv_valid),
      .addr   (rsv_addr),
      .onehot (rsv_onehot)
   );

   always_comb begin
      bank_d = bank_q;
      for (int unsigned i = 0; i < NREGS; i++) begin
         if (wr_onehot[i]) bank_d[i*REG_W +: REG_W] = wr_data;
      end
      // Reservation is applied after the clear so a same-cycle set wins.
      busy_d = (busy_q & ~wr_onehot) | rsv_onehot;
`ifdef REGBANK_R0_ZERO_EN
      bank_d[REG_W-1:0] = '0;
      busy_d[0]         = 1'b0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_q <= '0;
         busy_q <= '0;
      end else begin
         bank_q <= bank_d;
         busy_q <= busy_d;
      end
   end

   assign data_bus_out = bank_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_reg_bank_16x16.sv
// Directed plus random bench for reg_bank_16x16 against a queue-based reference model.
module tb_reg_bank_16x16;
   import cpu_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         a_valid, b_valid, rsv_valid;
   logic [3:0]   a_addr, b_addr, rsv_addr;
   logic [15:0]  a_data, b_data;
   logic         b_ready;
   logic [15:0]  busy;
   logic [255:0] data_bus_out;

   int checks = 0;
   int failures = 0;

   logic [15:0] m_regs [16];
   logic [15:0] m_busy;
   wb_entry_t   m_pend [$];

   reg_bank_16x16 dut (
      .clk          (clk),
      .rst          (rst),
      .a_valid      (a_valid),
      .a_addr       (a_addr),
      .a_data       (a_data),
      .b_valid      (b_valid),
      .b_ready      (b_ready),
      .b_addr       (b_addr),
      .b_data       (b_data),
      .rsv_valid    (rsv_valid),
      .rsv_addr     (rsv_addr),
      .busy         (busy),
      .data_bus_out (data_bus_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] m_flat();
      logic [255:0] f;
      for (int i = 0; i < 16; i++) f[i*16 +: 16] = m_regs[i];
      return f;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
      m_busy = 16'h0;
      m_pend.delete();
   endtask

   function automatic bit r0_zero();
`ifdef REGBANK_R0_ZERO_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic m_write(input logic [3:0] addr, input logic [15:0] data);
      if (!(r0_zero() && addr == 4'd0)) m_regs[addr] = data;
      m_busy[addr] = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".bus"}, data_bus_out, m_flat());
      chk({tag, ".busy"}, {240'h0, busy}, {240'h0, m_busy});
      chk({tag, ".b_ready"}, {255'h0, b_ready}, {255'h0, (m_pend.size() == 0)});
   endtask

   // One clock: drive inputs, advance the model, then compare after the edge.
   task automatic step(input string tag,
                       input logic av, input logic [3:0] aa, input logic [15:0] ad,
                       input logic bv, input logic [3:0] ba, input logic [15:0] bd,
                       input logic rv, input logic [3:0] ra);
      bit b_acc;
      wb_entry_t e;
      a_valid = av; a_addr = aa; a_data = ad;
      b_valid = bv; b_addr = ba; b_data = bd;
      rsv_valid = rv; rsv_addr = ra;
      b_acc = bv && (m_pend.size() == 0);
      if (av) begin
         m_write(aa, ad);
         if (m_pend.size() != 0 && m_pend[0].addr == aa) m_pend.delete();
         if (b_acc) m_pend.push_back('{addr: ba, data: bd});
      end else if (m_pend.size() != 0) begin
         e = m_pend.pop_front();
         m_write(e.addr, e.data);
      end else if (b_acc) begin
         m_write(ba, bd);
      end
      if (rv && !(r0_zero() && ra == 4'd0)) m_busy[ra] = 1'b1;
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
   endtask

   initial begin
      rst = 1'b1;
      a_valid = 1'b0; a_addr = '0; a_data = '0;
      b_valid = 1'b0; b_addr = '0; b_data = '0;
      rsv_valid = 1'b0; rsv_addr = '0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;
      idle("idle");

      step("a3", 1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
      chk("a3.reg3", {240'h0, data_bus_out[63:48]}, {240'h0, 16'hBEEF});

      step("ab_same", 1'b1, 4'd2, 16'h1111, 1'b1, 4'd5, 16'h2222, 1'b0, 4'd0);
      chk("ab_same.ready", {255'h0, b_ready}, 256'h0);
      idle("drain");
      chk("drain.reg5", {240'h0, data_bus_out[95:80]}, {240'h0, 16'h2222});
      chk("drain.ready", {255'h0, b_ready}, 256'h1);

      step("fill7", 1'b1, 4'd1, 16'h0001, 1'b1, 4'd7, 16'h00AA, 1'b0, 4'd0);
      step("kill7", 1'b1, 4'd7, 16'h0055, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
      chk("kill7.ready", {255'h0, b_ready}, 256'h1);
      idle("after_kill");
      chk("after_kill.reg7", {240'h0, data_bus_out[127:112]}, {240'h0, 16'h0055});

      step("rsv4", 1'b1, 4'd4, 16'h4444, 1'b0, 4'd0, 16'h0, 1'b1, 4'd4);
      chk("rsv4.busy4", {255'h0, busy[4]}, 256'h1);
      step("clr4", 1'b1, 4'd4, 16'h4545, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
      chk("clr4.busy4", {255'h0, busy[4]}, 256'h0);

      step("r0", 1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'h0, 1'b1, 4'd0);
`ifdef REGBANK_R0_ZERO_EN
      chk("r0.reg0", {240'h0, data_bus_out[15:0]}, 256'h0);
      chk("r0.busy0", {255'h0, busy[0]}, 256'h0);
`else
      chk("r0.reg0", {240'h0, data_bus_out[15:0]}, {240'h0, 16'hFFFF});
`endif

      // Reset while the slot holds a load: slot contents must vanish.
      step("fill9", 1'b1, 4'd8, 16'h0808, 1'b1, 4'd9, 16'h0999, 1'b0, 4'd0);
      a_valid = 1'b0; b_valid = 1'b0; rsv_valid = 1'b0;
      rst = 1'b1;
      #1;
      m_reset();
      check_all("mid_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle("post_rst");
      chk("post_rst.reg9", {240'h0, data_bus_out[159:144]}, 256'h0);

      for (int n = 0; n < 400; n++) begin
         step("rand",
              ($urandom_range(0, 99) < 60), 4'($urandom_range(0, 15)), 16'($urandom),
              ($urandom_range(0, 99) < 50), 4'($urandom_range(0, 15)), 16'($urandom),
              ($urandom_range(0, 99) < 30), 4'($urandom_range(0, 15)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
